// File: rtl/rgb_frame_scheduler.sv
// ----------------------------------------------------------------------------
// rgb_frame_scheduler
//
// Front end for a PL9823 serializer. Two requesters (A, B) write LED colours
// into an 8-entry shadow buffer under round-robin arbitration. On a commit
// (explicit COMMIT pulse or periodic refresh expiry) the shadow buffer is
// copied to PIX_OUT while the serializer is idle, and FRAME_START is pulsed
// so the serializer transmits the freshly published frame.
//
// Ports
//   CLK, RST_N          system clock (rising edge), async active-low reset
//   A_REQ/A_ADDR/A_DATA requester A write: LED index 0..7, colour {R,G,B}
//   A_ACK               one-cycle pulse, A write accepted
//   B_REQ/B_ADDR/B_DATA requester B write, same as A
//   B_ACK               one-cycle pulse, B write accepted
//   COMMIT              pulse: publish shadow buffer at next opportunity
//   TX_BUSY             serializer is transmitting
//   PIX_OUT             published buffer, LEDn at [24n-1 : 24(n-1)]
//   FRAME_START         one-cycle pulse: PIX_OUT valid, serializer may send
//   DIRTY               shadow written since the last publish
//   COMMIT_PEND         a commit is queued and not yet executed
// ----------------------------------------------------------------------------
module rgb_frame_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter int unsigned BUSY_TIMEOUT   = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         A_REQ,
    input  logic [2:0]   A_ADDR,
    input  logic [23:0]  A_DATA,
    output logic         A_ACK,
    input  logic         B_REQ,
    input  logic [2:0]   B_ADDR,
    input  logic [23:0]  B_DATA,
    output logic         B_ACK,
    input  logic         COMMIT,
    input  logic         TX_BUSY,
    output logic [191:0] PIX_OUT,
    output logic         FRAME_START,
    output logic         DIRTY,
    output logic         COMMIT_PEND
);

    localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0][23:0] shadow;
    logic             ptr_b;      // round-robin pointer: 0 = A first, 1 = B first
    logic [RW-1:0]    ref_cnt;
    logic [TW-1:0]    tmo_cnt;

    logic             elig_a;
    logic             elig_b;
    logic             grant_a;
    logic             grant_b;
    logic             grant_any;
    logic [2:0]       wr_addr;
    logic [23:0]      wr_data;
    logic             refresh_expire;
    logic             in_copy;

    // A port whose ACK is high this cycle is still holding REQ from the
    // accepted write; excluding it prevents a duplicate grant.
    assign elig_a    = A_REQ & ~A_ACK;
    assign elig_b    = B_REQ & ~B_ACK;
    assign grant_a   = elig_a & (~elig_b | ~ptr_b);
    assign grant_b   = elig_b & (~elig_a |  ptr_b);
    assign grant_any = grant_a | grant_b;
    assign wr_addr   = grant_a ? A_ADDR : B_ADDR;
    assign wr_data   = grant_a ? A_DATA : B_DATA;

    assign refresh_expire = (ref_cnt == REF_LAST);
    assign in_copy        = (state == COPY);

    // ------------------------------------------------------------------
    // Arbitration, shadow writes and acknowledges
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow <= '0;
            ptr_b  <= 1'b0;
            A_ACK  <= 1'b0;
            B_ACK  <= 1'b0;
        end else begin
            A_ACK <= grant_a;
            B_ACK <= grant_b;
            if (elig_a && elig_b) begin
                ptr_b <= ~ptr_b;
            end
            if (grant_any) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Publish path and status flags. Sets take priority over the clear
    // performed in COPY, so a write or commit landing on the COPY cycle
    // is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PIX_OUT     <= '0;
            DIRTY       <= 1'b0;
            COMMIT_PEND <= 1'b0;
        end else begin
            if (in_copy) begin
                PIX_OUT <= shadow;
            end

            if (grant_any) begin
                DIRTY <= 1'b1;
            end else if (in_copy) begin
                DIRTY <= 1'b0;
            end

            if (COMMIT || refresh_expire) begin
                COMMIT_PEND <= 1'b1;
            end else if (in_copy) begin
                COMMIT_PEND <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh interval and TX_BUSY handshake timeout counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ref_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (in_copy || refresh_expire) begin
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end

            if (state == START) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_HI && tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        FRAME_START = 1'b0;
        case (state)
            IDLE: begin
                // Never publish while a transmission is in progress.
                if (COMMIT_PEND && !TX_BUSY) begin
                    state_next = COPY;
                end
            end
            COPY: begin
                state_next = START;
            end
            START: begin
                FRAME_START = 1'b1;
                state_next  = WAIT_HI;
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_next = WAIT_LO;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb_frame_scheduler.sv
module tb_rgb_frame_scheduler;

    localparam int unsigned REF_MAIN = 1000;
    localparam int unsigned REF_FAST = 8;
    localparam int unsigned BT       = 16;

    logic         CLK;
    logic         RST_N;
    logic         A_REQ, B_REQ, COMMIT, TX_BUSY;
    logic [2:0]   A_ADDR, B_ADDR;
    logic [23:0]  A_DATA, B_DATA;
    logic         A_ACK, B_ACK, FRAME_START, DIRTY, COMMIT_PEND;
    logic [191:0] PIX_OUT;

    // Second instance with a short refresh interval; its requesters stay idle.
    logic         r_a_req, r_b_req, r_commit, r_busy;
    logic [2:0]   r_a_addr, r_b_addr;
    logic [23:0]  r_a_data, r_b_data;
    logic         r_a_ack, r_b_ack, r_fs, r_dirty, r_pend;
    logic [191:0] r_pix;

    rgb_frame_scheduler #(.REFRESH_CYCLES(REF_MAIN), .BUSY_TIMEOUT(BT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_ACK(A_ACK),
        .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_ACK(B_ACK),
        .COMMIT(COMMIT), .TX_BUSY(TX_BUSY), .PIX_OUT(PIX_OUT),
        .FRAME_START(FRAME_START), .DIRTY(DIRTY), .COMMIT_PEND(COMMIT_PEND)
    );

    rgb_frame_scheduler #(.REFRESH_CYCLES(REF_FAST), .BUSY_TIMEOUT(BT)) dut_r (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(r_a_req), .A_ADDR(r_a_addr), .A_DATA(r_a_data), .A_ACK(r_a_ack),
        .B_REQ(r_b_req), .B_ADDR(r_b_addr), .B_DATA(r_b_data), .B_ACK(r_b_ack),
        .COMMIT(r_commit), .TX_BUSY(r_busy), .PIX_OUT(r_pix),
        .FRAME_START(r_fs), .DIRTY(r_dirty), .COMMIT_PEND(r_pend)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: what each LED should hold, and the last published image.
    logic [23:0]  m_shadow [8];
    logic [191:0] m_pix;

    function automatic logic [191:0] pack_model();
        logic [191:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[i*24 +: 24] = m_shadow[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (FRAME_START !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Play the serializer: busy for k cycles after FRAME_START, then idle.
    task automatic serve(input int k);
        TX_BUSY = 1'b1;
        repeat (k) tick();
        TX_BUSY = 1'b0;
        tick();
        tick();
    endtask

    // Uncontested write; REQ is held through the ACK cycle to show it is
    // not granted twice.
    task automatic write_one(input bit on_b, input logic [2:0] addr, input logic [23:0] data);
        if (on_b) begin
            B_REQ = 1'b1; B_ADDR = addr; B_DATA = data;
        end else begin
            A_REQ = 1'b1; A_ADDR = addr; A_DATA = data;
        end
        tick();
        chk("wr_ack",       on_b ? B_ACK : A_ACK, 1);
        chk("wr_other_ack", on_b ? A_ACK : B_ACK, 0);
        chk("wr_dirty",     DIRTY, 1);
        m_shadow[addr] = data;
        tick();
        chk("wr_ack_once",  on_b ? B_ACK : A_ACK, 0);
        A_REQ = 1'b0;
        B_REQ = 1'b0;
    endtask

    task automatic commit_frame();
        int n;
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        chk("cf_pend_set", COMMIT_PEND, 1);
        wait_fs(n);
        chk("cf_latency", n, 2);
        m_pix = pack_model();
        chk("cf_pix",       PIX_OUT, m_pix);
        chk("cf_dirty_clr", DIRTY, 0);
        chk("cf_pend_clr",  COMMIT_PEND, 0);
        serve(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        logic [23:0] ra, rb, old_val;
        logic [2:0]  addr;
        logic [191:0] old_pix;

        RST_N = 1'b0;
        A_REQ = 0; B_REQ = 0; COMMIT = 0; TX_BUSY = 0;
        A_ADDR = '0; B_ADDR = '0; A_DATA = '0; B_DATA = '0;
        r_a_req = 0; r_b_req = 0; r_commit = 0; r_busy = 0;
        r_a_addr = '0; r_b_addr = '0; r_a_data = '0; r_b_data = '0;
        for (int i = 0; i < 8; i++) m_shadow[i] = '0;
        m_pix = '0;

        // Reset state
        #12;
        chk("rst_pix",   PIX_OUT, 0);
        chk("rst_a_ack", A_ACK, 0);
        chk("rst_b_ack", B_ACK, 0);
        chk("rst_fs",    FRAME_START, 0);
        chk("rst_dirty", DIRTY, 0);
        chk("rst_pend",  COMMIT_PEND, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // LED3 red, then publish
        write_one(0, 3'd2, 24'hFF0000);
        commit_frame();
        chk("led3_only", PIX_OUT, {120'h0, 24'hFF0000, 48'h0});

        // Contested requests, pointer starts at A
        A_REQ = 1; A_ADDR = 0; A_DATA = 24'h000011;
        B_REQ = 1; B_ADDR = 0; B_DATA = 24'h000022;
        tick();
        chk("rr1_a_ack", A_ACK, 1);
        chk("rr1_b_ack", B_ACK, 0);
        A_REQ = 0;
        tick();
        chk("rr1_b_ack2", B_ACK, 1);
        chk("rr1_a_ack2", A_ACK, 0);
        B_REQ = 0;
        m_shadow[0] = 24'h000022;
        tick();
        commit_frame();

        // Second contest: pointer now at B
        ra = 24'($urandom);
        rb = 24'($urandom);
        A_REQ = 1; A_ADDR = 0; A_DATA = ra;
        B_REQ = 1; B_ADDR = 0; B_DATA = rb;
        tick();
        chk("rr2_b_ack", B_ACK, 1);
        chk("rr2_a_ack", A_ACK, 0);
        B_REQ = 0;
        tick();
        chk("rr2_a_ack2", A_ACK, 1);
        chk("rr2_b_ack2", B_ACK, 0);
        A_REQ = 0;
        m_shadow[0] = ra;
        tick();
        commit_frame();

        // Random writes from either port
        for (int i = 0; i < 12; i++)
            write_one(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 24'($urandom));
        commit_frame();

        // Commit held off by an ongoing transmission
        write_one(1, 3'($urandom_range(0, 7)), 24'($urandom));
        TX_BUSY = 1'b1;
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (FRAME_START === 1'b1) seen = 1;
            if (i % 25 == 24) begin
                chk("busy_pend", COMMIT_PEND, 1);
                chk("busy_pix",  PIX_OUT, m_pix);
            end
        end
        chk("busy_no_fs", seen, 0);
        TX_BUSY = 1'b0;
        wait_fs(n);
        chk("busy_release_lat", n, 2);
        m_pix = pack_model();
        chk("busy_pix_after", PIX_OUT, m_pix);
        serve(3);

        // B write granted in the COPY cycle
        old_pix = pack_model();
        addr    = 3'($urandom_range(0, 7));
        old_val = m_shadow[addr] ^ 24'h5A5A5A;
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        tick();
        B_REQ = 1; B_ADDR = addr; B_DATA = old_val;
        tick();
        chk("copyw_fs",    FRAME_START, 1);
        chk("copyw_pix",   PIX_OUT, old_pix);
        chk("copyw_b_ack", B_ACK, 1);
        chk("copyw_dirty", DIRTY, 1);
        B_REQ = 0;
        m_shadow[addr] = old_val;
        m_pix = old_pix;
        serve(3);
        commit_frame();

        // COMMIT in the COPY cycle yields a second frame
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        tick();
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        chk("copyc_fs",   FRAME_START, 1);
        chk("copyc_pend", COMMIT_PEND, 1);
        chk("copyc_pix",  PIX_OUT, pack_model());
        TX_BUSY = 1'b1;
        tick(); tick(); tick();
        n = 3;
        TX_BUSY = 1'b0;
        while (FRAME_START !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("copyc_second_gap", n, 6);
        serve(3);
        chk("copyc_pend_done", COMMIT_PEND, 0);

        // Serializer ignores the frame: WAIT_HI times out, queued commit runs
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        wait_fs(n);
        chk("tmo_first_lat", n, 2);
        n = 0;
        tick();
        n++;
        COMMIT = 1'b1;
        tick();
        n++;
        COMMIT = 1'b0;
        while (FRAME_START !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("tmo_gap", n, BT + 3);
        serve(3);

        // Asynchronous reset during WAIT_LO with an ACK in flight
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        wait_fs(n);
        chk("rstmid_lat", n, 2);
        TX_BUSY = 1'b1;
        tick();
        A_REQ = 1; A_ADDR = 3'($urandom_range(0, 7)); A_DATA = 24'($urandom);
        tick();
        chk("rstmid_ack_inflight", A_ACK, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rstmid_pix",   PIX_OUT, 0);
        chk("rstmid_a_ack", A_ACK, 0);
        chk("rstmid_b_ack", B_ACK, 0);
        chk("rstmid_fs",    FRAME_START, 0);
        chk("rstmid_dirty", DIRTY, 0);
        chk("rstmid_pend",  COMMIT_PEND, 0);
        A_REQ = 0;
        TX_BUSY = 0;
        for (int i = 0; i < 8; i++) m_shadow[i] = '0;
        m_pix = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // Automatic refresh on the short-interval instance
        n = 0;
        while (r_fs !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ref_first_fs", r_fs, 1);
        for (int k = 0; k < 3; k++) begin
            r_busy = 1'b1;
            tick(); tick(); tick();
            n = 3;
            r_busy = 1'b0;
            while (r_fs !== 1'b1 && n < 60) begin
                tick();
                n++;
            end
            chk("ref_gap",   n, REF_FAST + 2);
            chk("ref_pix",   r_pix, 0);
            chk("ref_dirty", r_dirty, 0);
        end

        // Shadow buffer was cleared by reset
        commit_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
